// File: rtl/exc_pkg.sv
// ============================================================================
// exc_pkg
// Shared types and helpers for the LEGv8 exception/interrupt controller.
// Rev 1.0
// ============================================================================
`default_nettype none

package exc_pkg;

    typedef enum logic [3:0] {
        CAUSE_NONE   = 4'h0,
        CAUSE_IRQ    = 4'h1,
        CAUSE_UNDEF  = 4'h2,
        CAUSE_DFAULT = 4'h3
    } cause_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        LOCKED  = 2'd2
    } exc_state_t;

    localparam int ESR_W         = 8;
    localparam int ESR_CAUSE_LSB = 0;
    localparam int ESR_CAUSE_W   = 4;
    localparam int ESR_IDX_LSB   = 4;
    localparam int ESR_IDX_W     = 4;

    // Position of the single set bit of a one-hot vector (0 when empty).
    function automatic logic [3:0] onehot_to_idx(input logic [7:0] onehot);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Pack an IRQ index and cause code into the syndrome layout.
    function automatic logic [ESR_W-1:0] make_esr(input logic [3:0] idx, input cause_t cause);
        logic [ESR_W-1:0] esr;
        esr = '0;
        esr[ESR_IDX_LSB +: ESR_IDX_W]     = idx;
        esr[ESR_CAUSE_LSB +: ESR_CAUSE_W] = cause;
        return esr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_sync.sv
// ============================================================================
// irq_sync
// Two-flop synchroniser for one asynchronous interrupt line plus a third flop
// used to detect the synchronised rising edge.
// Rev 1.0
// ============================================================================
`default_nettype none

module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Metastability chain followed by the edge-history flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

endmodule

`default_nettype wire

// File: rtl/exception_unit.sv
// ============================================================================
// exception_unit
// Exception/interrupt controller for the single-cycle LEGv8 core: latches
// external IRQ edges, arbitrates them against invalid-opcode faults, captures
// ELR/ESR, pulses redirects to fetch and tracks handler / lock-up state.
// Rev 1.0
// ============================================================================
`default_nettype none

module exception_unit
    import exc_pkg::*;
#(
    parameter int          N      = 64,
    parameter int          N_IRQ  = 4,
    parameter logic [63:0] VECTOR = 64'h0000_0000_0000_00D8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             irq_en_wr,
    input  logic [N_IRQ-1:0] irq_en_data,
    input  logic             instr_valid,
    input  logic             not_an_instr,
    input  logic             eret,
    input  logic [N-1:0]     pc_i,
    output logic             exc_take,
    output logic             eret_take,
    output logic [N-1:0]     pc_redirect,
    output logic [N-1:0]     elr_o,
    output logic [ESR_W-1:0] esr_o,
    output logic             in_handler,
    output logic             halt,
    output logic [N_IRQ-1:0] irq_pending
);

    exc_state_t       state;
    logic [N_IRQ-1:0] enable;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] win_onehot;
    logic [7:0]       win_wide;
    logic [3:0]       win_idx;
    logic             take_irq;
    logic             take_undef;

    generate
        for (genvar i = 0; i < N_IRQ; i++) begin : g_irq_sync
            irq_sync u_irq_sync (
                .clk   (clk),
                .reset (reset),
                .irq   (irq[i]),
                .rise  (rise[i])
            );
        end
    endgenerate

    // Lowest eligible index wins: isolate the least-significant set bit.
    assign eligible   = irq_pending & enable;
    assign win_onehot = eligible & (~eligible + N_IRQ'(1));

    // Widen the winner so the shared index helper works for any line count.
    always_comb begin
        win_wide                = '0;
        win_wide[N_IRQ-1:0]     = win_onehot;
    end

    assign win_idx    = onehot_to_idx(win_wide);
    assign take_irq   = (state == RUN) && instr_valid && (|eligible);
    assign take_undef = (state == RUN) && instr_valid && !take_irq && (not_an_instr || eret);

    // Controller FSM with registered pulses, capture registers and IRQ bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            enable      <= '1;
            irq_pending <= '0;
            exc_take    <= 1'b0;
            eret_take   <= 1'b0;
            pc_redirect <= '0;
            elr_o       <= '0;
            esr_o       <= '0;
        end else begin
            exc_take    <= 1'b0;
            eret_take   <= 1'b0;
            pc_redirect <= '0;
            case (state)
                RUN: begin
                    if (irq_en_wr) enable <= irq_en_data;
                    // The taken line is cleared, but a fresh edge on any line still latches.
                    irq_pending <= (irq_pending & ~(take_irq ? win_onehot : '0)) | rise;
                    if (take_irq) begin
                        exc_take    <= 1'b1;
                        pc_redirect <= VECTOR[N-1:0];
                        elr_o       <= pc_i;
                        esr_o       <= make_esr(win_idx, CAUSE_IRQ);
                        state       <= HANDLER;
                    end else if (take_undef) begin
                        // ERET outside a handler is treated as an invalid opcode.
                        exc_take    <= 1'b1;
                        pc_redirect <= VECTOR[N-1:0];
                        elr_o       <= pc_i;
                        esr_o       <= make_esr(4'h0, CAUSE_UNDEF);
                        state       <= HANDLER;
                    end
                end
                HANDLER: begin
                    if (irq_en_wr) enable <= irq_en_data;
                    irq_pending <= irq_pending | rise;
                    if (instr_valid && not_an_instr) begin
                        // Fault inside the handler: keep the original ELR for post-mortem.
                        esr_o <= make_esr(4'h0, CAUSE_DFAULT);
                        state <= LOCKED;
                    end else if (instr_valid && eret) begin
                        eret_take   <= 1'b1;
                        pc_redirect <= elr_o;
                        state       <= RUN;
                    end
                end
                LOCKED: begin
                    // Absorbing: only reset leaves this state.
                end
                default: state <= RUN;
            endcase
        end
    end

    assign in_handler = (state == HANDLER);
    assign halt       = (state == LOCKED);

endmodule

`default_nettype wire
